vram_console_writer: RTL

VRAM_CONSOLE_WRITER -- requirements
Module: vram_console_writer

---
 rtl/vram_console_writer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/vram_console_writer.sv
// Character console that turns a byte stream into VRAM cell writes, handling
// cursor control codes, full-screen clear and a read/copy scroll of the text plane.
module vram_console_writer #(
    parameter int COLS           = 64,
    parameter int ROWS           = 30,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TX_VALID,
    input  logic [7:0]  TX_DATA,
    output logic        TX_READY,
    output logic        VRAM_CS,
    output logic        VRAM_WR,
    output logic [10:0] VRAM_A,
    output logic [7:0]  VRAM_DO,
    input  logic [7:0]  VRAM_DI,
    input  logic        VRAM_WAIT,
    output logic [4:0]  CUR_ROW,
    output logic [5:0]  CUR_COL,
    output logic        BUSY
);
    typedef enum logic [2:0] {
        S_RESET_CLR, S_IDLE, S_PUT, S_SCR_RD, S_SCR_WR, S_FILL, S_CLS
    } state_t;

    localparam logic [10:0] COLS_A     = 11'(COLS);
    localparam logic [10:0] LAST_A     = 11'(ROWS * COLS - 1);
    localparam logic [10:0] SCR_LAST_A = 11'((ROWS - 1) * COLS - 1);
    localparam logic [4:0]  ROW_LAST   = 5'(ROWS - 1);
    localparam logic [5:0]  COL_LAST   = 6'(COLS - 1);
    localparam logic [7:0]  SPACE      = 8'h20;

    state_t      r_state;
    logic        r_cs, r_wr, r_ready, r_wrap;
    logic [10:0] r_a;
    logic [7:0]  r_do;
    logic [4:0]  r_row;
    logic [5:0]  r_col;

    logic        w_done;
    logic [10:0] w_cur_addr;

    assign w_done     = r_cs & ~VRAM_WAIT;
    assign w_cur_addr = {6'd0, r_row} * COLS_A + {5'd0, r_col};

    assign TX_READY = r_ready;
    assign VRAM_CS  = r_cs;
    assign VRAM_WR  = r_wr;
    assign VRAM_A   = r_a;
    assign VRAM_DO  = r_do;
    assign CUR_ROW  = r_row;
    assign CUR_COL  = r_col;
    assign BUSY     = (r_state != S_IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_RESET_CLR;
            r_cs    <= 1'b0;
            r_wr    <= 1'b0;
            r_a     <= '0;
            r_do    <= '0;
            r_ready <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            case (r_state)
                // RESET_CLR starts with the bus idle; once its first access is issued it runs as CLS
                S_RESET_CLR, S_CLS: begin
                    if (!r_cs) begin
                        if (CLEAR_ON_RESET != 0) begin
                            r_cs <= 1'b1;
                            r_wr <= 1'b1;
                            r_a  <= '0;
                            r_do <= SPACE;
                        end else begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                        end
                    end else if (w_done) begin
                        if (r_a == LAST_A) begin
                            r_cs    <= 1'b0;
                            r_wr    <= 1'b0;
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            r_row   <= '0;
                            r_col   <= '0;
                        end else begin
                            r_a <= r_a + 11'd1;
                        end
                    end
                end
                S_IDLE: begin
                    if (TX_VALID && r_ready) begin
                        if (TX_DATA >= 8'h20) begin
                            r_state <= S_PUT;
                            r_ready <= 1'b0;
                            r_cs    <= 1'b1;
                            r_wr    <= 1'b1;
                            r_a     <= w_cur_addr;
                            r_do    <= TX_DATA;
                        end else begin
                            case (TX_DATA)
                                8'h0D: r_col <= '0;
                                8'h0A: begin
                                    if (r_row != ROW_LAST) begin
                                        r_row <= r_row + 5'd1;
                                    end else begin
                                        r_state <= S_SCR_RD;
                                        r_ready <= 1'b0;
                                        r_cs    <= 1'b1;
                                        r_wr    <= 1'b0;
                                        r_a     <= COLS_A;
                                        r_wrap  <= 1'b0;
                                    end
                                end
                                8'h08: begin
                                    if (r_col != 6'd0) r_col <= r_col - 6'd1;
                                end
                                8'h0C: begin
                                    r_state <= S_CLS;
                                    r_ready <= 1'b0;
                                    r_cs    <= 1'b1;
                                    r_wr    <= 1'b1;
                                    r_a     <= '0;
                                    r_do    <= SPACE;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_PUT: begin
                    if (w_done) begin
                        if (r_col != COL_LAST) begin
                            r_col   <= r_col + 6'd1;
                            r_cs    <= 1'b0;
                            r_wr    <= 1'b0;
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                        end else if (r_row != ROW_LAST) begin
                            r_col   <= '0;
                            r_row   <= r_row + 5'd1;
                            r_cs    <= 1'b0;
                            r_wr    <= 1'b0;
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                        end else begin
                            // Bottom-right wrap: column returns to 0 only when the scroll finishes
                            r_state <= S_SCR_RD;
                            r_wr    <= 1'b0;
                            r_a     <= COLS_A;
                            r_wrap  <= 1'b1;
                        end
                    end
                end
                S_SCR_RD: begin
                    if (w_done) begin
                        r_state <= S_SCR_WR;
                        r_wr    <= 1'b1;
                        r_a     <= r_a - COLS_A;
                        r_do    <= VRAM_DI;
                    end
                end
                S_SCR_WR: begin
                    if (w_done) begin
                        if (r_a == SCR_LAST_A) begin
                            r_state <= S_FILL;
                            r_a     <= r_a + 11'd1;
                            r_do    <= SPACE;
                        end else begin
                            r_state <= S_SCR_RD;
                            r_wr    <= 1'b0;
                            r_a     <= r_a + COLS_A + 11'd1;
                        end
                    end
                end
                S_FILL: begin
                    if (w_done) begin
                        if (r_a == LAST_A) begin
                            r_cs    <= 1'b0;
                            r_wr    <= 1'b0;
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            if (r_wrap) r_col <= '0;
                        end else begin
                            r_a <= r_a + 11'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cs    <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
